instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of `data_path`: it consumes the `pc` that `data_path` drives and returns the matching `instr`. Instructions are prefetched sequentially from an instruction memory over a req/ack handshake into a small in-order buffer. A `pc` that leaves the sequential stream flushes the buffer and restarts fetching at the new address.

---
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential prefetch into a DEPTH-entry in-order buffer, flushed on a pc discontinuity.
// Optional build macro IFU_BYPASS_EN forwards an acked word straight to instr while the buffer is empty.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   base_q, base_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          drop_q, drop_d;
    logic [31:0]   fifo_q [DEPTH];

    logic [31:0]   pc_al_s;
    logic [PW-1:0] next_s, tail_s;
    logic          aligned_s, hit0_s, hit1_s, adv_s, wait_s, miss_s;
    logic          pop_s, ack_s, wr_s;

    // Classify the requested pc against the buffered window.
    always_comb begin
        pc_al_s   = {pc[31:2], 2'b00};
        aligned_s = (pc[1:0] == 2'b00);
        hit0_s    = aligned_s && (count_q >= CW'(1)) && (pc == base_q);
        hit1_s    = aligned_s && (count_q >= CW'(2)) && (pc == base_q + 32'd4);
        adv_s     = aligned_s && (count_q == CW'(1)) && (pc == base_q + 32'd4);
        wait_s    = aligned_s && (count_q == CW'(0)) && (pc == base_q);
        miss_s    = !(hit0_s || hit1_s || adv_s || wait_s);
        pop_s     = hit1_s || adv_s;
        ack_s     = mem_req_q && mem_ack;
        wr_s      = ack_s && !drop_q && !miss_s;
        next_s    = head_q + PW'(1);
        tail_s    = head_q + count_q[PW-1:0];
    end

    // Instruction output mux.
    always_comb begin
        instr_valid = 1'b0;
        instr       = 32'h0000_0000;
        if (hit0_s) begin
            instr_valid = 1'b1;
            instr       = fifo_q[head_q];
        end else if (hit1_s) begin
            instr_valid = 1'b1;
            instr       = fifo_q[next_s];
`ifdef IFU_BYPASS_EN
        end else if (wait_s && ack_s && !drop_q && (mem_addr_q == pc)) begin
            instr_valid = 1'b1;
            instr       = mem_rdata;
`endif
        end else begin
            instr_valid = 1'b0;
            instr       = 32'h0000_0000;
        end
    end

    // Next-state: buffer window, request address and flush/drop handling.
    always_comb begin
        base_d     = base_q;
        count_d    = count_q;
        head_d     = head_q;
        drop_d     = drop_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        if (miss_s) begin
            base_d    = pc_al_s;
            count_d   = CW'(0);
            head_d    = PW'(0);
            mem_req_d = 1'b1;
            // An outstanding un-acked request must complete first; its data is discarded.
            if (mem_req_q && !mem_ack) begin
                drop_d = 1'b1;
            end else begin
                drop_d     = 1'b0;
                mem_addr_d = pc_al_s;
            end
        end else begin
            if (pop_s) begin
                base_d = base_q + 32'd4;
                head_d = next_s;
            end else begin
                base_d = base_q;
                head_d = head_q;
            end
            count_d = count_q - CW'(pop_s) + CW'(wr_s);
            if (drop_q && ack_s) begin
                drop_d     = 1'b0;
                mem_addr_d = base_q;
            end else if (wr_s) begin
                mem_addr_d = mem_addr_q + 32'd4;
            end else begin
                mem_addr_d = mem_addr_q;
            end
            mem_req_d = (count_d < DEPTH_C);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q     <= RESET_PC;
            count_q    <= CW'(0);
            head_q     <= PW'(0);
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
        end else begin
            base_q     <= base_d;
            count_q    <= count_d;
            head_q     <= head_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            drop_q     <= drop_d;
        end
    end

    // Prefetch data storage, written at the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= 32'h0000_0000;
            end
        end else if (wr_s) begin
            fifo_q[tail_s] <= mem_rdata;
        end else begin
            fifo_q[tail_s] <= fifo_q[tail_s];
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: random/directed pc streams against a queue-based fetch model.
module tb_instr_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFU_BYPASS_EN
    localparam int FIRST_VALID = 1;
`else
    localparam int FIRST_VALID = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // memory and reference model state
    logic [31:0] salt;
    int          ws, wcnt;
    logic        rand_ws;
    logic [31:0] m_base, m_addr;
    logic        m_req, m_drop;
    logic [31:0] m_q[$];
    logic        exp_valid, cur_pop, cur_miss;
    logic [31:0] exp_instr, cur_pc;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ salt;
    endfunction

    task automatic model_reset();
        m_base = RESET_PC; m_addr = RESET_PC; m_req = 1'b0; m_drop = 1'b0;
        m_q.delete(); wcnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; mem_ack = 1'b0; pc = RESET_PC;
        @(negedge clk); @(negedge clk);
        reset = 1'b1; ws = 0; rand_ws = 1'b0;
        model_reset();
    endtask

    // Drive pc and the memory response, then work out what the fetch stage should show.
    task automatic set_inputs(input logic [31:0] p);
        logic [31:0] pa, off;
        pc = p; cur_pc = p;
        mem_ack = m_req && (wcnt >= ws);
        mem_rdata = word_at(mem_addr);
        pa = {p[31:2], 2'b00};
        off = pa - m_base;
        exp_valid = 1'b0; exp_instr = 32'h0; cur_pop = 1'b0; cur_miss = 1'b0;
        if (p[1:0] != 2'b00) cur_miss = 1'b1;
        else if (off == 32'd0 && m_q.size() >= 1) begin exp_valid = 1'b1; exp_instr = m_q[0]; end
        else if (off == 32'd4 && m_q.size() >= 2) begin exp_valid = 1'b1; exp_instr = m_q[1]; cur_pop = 1'b1; end
        else if (off == 32'd4 && m_q.size() == 1) cur_pop = 1'b1;
        else if (off == 32'd0) begin
`ifdef IFU_BYPASS_EN
            if (mem_ack && !m_drop && m_addr == pa) begin exp_valid = 1'b1; exp_instr = word_at(m_addr); end
`endif
        end
        else cur_miss = 1'b1;
        #1;
    endtask

    // Clock edge: apply the fetch rules to the model, then return at the next falling edge.
    task automatic advance();
        logic acc, old_req;
        acc = m_req && mem_ack;
        old_req = m_req;
        @(posedge clk);
        if (cur_miss) begin
            m_drop = m_req && !mem_ack;
            m_q.delete();
            m_base = {cur_pc[31:2], 2'b00};
        end else begin
            if (cur_pop) begin void'(m_q.pop_front()); m_base = m_base + 32'd4; end
            if (acc && m_drop) m_drop = 1'b0;
            else if (acc) m_q.push_back(word_at(m_addr));
        end
        if (!m_drop) m_addr = m_base + 32'(4 * m_q.size());
        m_req = m_drop || (m_q.size() < DEPTH);
        if (acc) begin
            wcnt = 0;
            if (rand_ws) ws = $urandom_range(0, 2);
        end else if (old_req) wcnt++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_ack = 1'b0; pc = 32'h0; mem_rdata = 32'h0;
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got v=%b i=%h want 0/0", instr_valid, instr); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
        total++; if (mem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr: got %h want %h", mem_addr, RESET_PC); end
        @(negedge clk);
    endtask

    task automatic test_first_fetch();
        do_reset(); salt = 32'h03A0_3002;
        for (int i = 0; i < 5; i++) begin
            set_inputs(32'h0);
            total++; if ({instr_valid, instr, mem_req, mem_addr} !== {exp_valid, exp_instr, m_req, m_addr}) begin bad++; $display("FAIL first_model c%0d: got v=%b i=%h r=%b a=%h want v=%b i=%h r=%b a=%h", i, instr_valid, instr, mem_req, mem_addr, exp_valid, exp_instr, m_req, m_addr); end
            if (i == 1) begin
                total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL first_req: got r=%b a=%h want 1/00000000", mem_req, mem_addr); end
            end
            if (i < FIRST_VALID) begin
                total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL first_early c%0d: got v=%b want 0", i, instr_valid); end
            end else if (i == FIRST_VALID) begin
                total++; if (instr_valid !== 1'b1 || instr !== 32'h03A0_3002) begin bad++; $display("FAIL first_instr: got v=%b i=%h want 1/03a03002", instr_valid, instr); end
            end
            advance();
        end
        salt = 32'h0;
    endtask

    // Hold start_pc while the buffer fills, then step pc every cycle expecting a valid word each time.
    task automatic test_stream(input logic [31:0] start_pc, input int steps);
        logic [31:0] p;
        do_reset(); salt = 32'h0;
        for (int i = 0; i < 3; i++) begin
            set_inputs(start_pc);
            total++; if ({instr_valid, instr, mem_req, mem_addr} !== {exp_valid, exp_instr, m_req, m_addr}) begin bad++; $display("FAIL stream_fill c%0d: got v=%b i=%h r=%b a=%h want v=%b i=%h r=%b a=%h", i, instr_valid, instr, mem_req, mem_addr, exp_valid, exp_instr, m_req, m_addr); end
            advance();
        end
        p = start_pc;
        for (int i = 0; i < steps; i++) begin
            set_inputs(p);
            total++; if ({instr_valid, instr, mem_req, mem_addr} !== {exp_valid, exp_instr, m_req, m_addr}) begin bad++; $display("FAIL stream_model pc=%h: got v=%b i=%h r=%b a=%h want v=%b i=%h r=%b a=%h", p, instr_valid, instr, mem_req, mem_addr, exp_valid, exp_instr, m_req, m_addr); end
            total++; if (instr_valid !== 1'b1 || instr !== p) begin bad++; $display("FAIL stream_instr pc=%h: got v=%b i=%h want 1/%h", p, instr_valid, instr, p); end
            advance();
            p = p + 32'd4;
        end
    endtask

    task automatic test_wait_states();
        do_reset(); ws = 3;
        for (int i = 0; i < 40; i++) begin
            set_inputs(32'h8);
            total++; if ({instr_valid, instr, mem_req, mem_addr} !== {exp_valid, exp_instr, m_req, m_addr}) begin bad++; $display("FAIL wait_model c%0d: got v=%b i=%h r=%b a=%h want v=%b i=%h r=%b a=%h", i, instr_valid, instr, mem_req, mem_addr, exp_valid, exp_instr, m_req, m_addr); end
            advance();
        end
        set_inputs(32'h8);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL wait_full_req: got %b want 0", mem_req); end
        total++; if (instr_valid !== 1'b1 || instr !== 32'h8) begin bad++; $display("FAIL wait_instr: got v=%b i=%h want 1/00000008", instr_valid, instr); end
        advance();
    endtask

    task automatic test_flush_drop();
        logic got_ack, after_ack, done;
        do_reset(); ws = 3;
        for (int i = 0; i < 60 && m_q.size() != DEPTH; i++) begin
            set_inputs(32'h10);
            total++; if ({instr_valid, instr, mem_req, mem_addr} !== {exp_valid, exp_instr, m_req, m_addr}) begin bad++; $display("FAIL drop_fill c%0d: got v=%b i=%h r=%b a=%h want v=%b i=%h r=%b a=%h", i, instr_valid, instr, mem_req, mem_addr, exp_valid, exp_instr, m_req, m_addr); end
            advance();
        end
        total++; if (m_q.size() != DEPTH) begin bad++; $display("FAIL drop_fill_timeout: got %0d want %0d", m_q.size(), DEPTH); end
        set_inputs(32'h14);
        total++; if (instr_valid !== 1'b1 || instr !== 32'h14) begin bad++; $display("FAIL drop_pop: got v=%b i=%h want 1/00000014", instr_valid, instr); end
        advance();
        set_inputs(32'h100);
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h20 || instr_valid !== 1'b0) begin bad++; $display("FAIL drop_jump: got r=%b a=%h v=%b want 1/00000020/0", mem_req, mem_addr, instr_valid); end
        advance();
        got_ack = 1'b0; after_ack = 1'b0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            set_inputs(32'h100);
            total++; if ({instr_valid, instr, mem_req, mem_addr} !== {exp_valid, exp_instr, m_req, m_addr}) begin bad++; $display("FAIL drop_model c%0d: got v=%b i=%h r=%b a=%h want v=%b i=%h r=%b a=%h", i, instr_valid, instr, mem_req, mem_addr, exp_valid, exp_instr, m_req, m_addr); end
            if (!got_ack) begin
                total++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin bad++; $display("FAIL drop_hold: got r=%b a=%h want 1/00000020", mem_req, mem_addr); end
            end else if (after_ack) begin
                total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin bad++; $display("FAIL drop_restart: got r=%b a=%h want 1/00000100", mem_req, mem_addr); end
                after_ack = 1'b0;
            end
            if (instr_valid === 1'b1) begin
                total++; if (instr !== 32'h100) begin bad++; $display("FAIL drop_instr: got %h want 00000100", instr); end
                done = 1'b1;
            end
            if (mem_ack && !got_ack) begin got_ack = 1'b1; after_ack = 1'b1; end
            advance();
        end
        total++; if (!done) begin bad++; $display("FAIL drop_timeout: got no valid want valid at 00000100"); end
    endtask

    task automatic test_reset_midop();
        do_reset(); ws = 0;
        for (int i = 0; i < 20 && !(m_q.size() == 3 && m_req); i++) begin
            set_inputs(32'h0);
            total++; if ({instr_valid, instr, mem_req, mem_addr} !== {exp_valid, exp_instr, m_req, m_addr}) begin bad++; $display("FAIL rst_fill c%0d: got v=%b i=%h r=%b a=%h want v=%b i=%h r=%b a=%h", i, instr_valid, instr, mem_req, mem_addr, exp_valid, exp_instr, m_req, m_addr); end
            advance();
        end
        pc = 32'h0; mem_ack = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin bad++; $display("FAIL rst_async: got r=%b v=%b i=%h want 0/0/0", mem_req, instr_valid, instr); end
        mem_ack = 1'b1;
        @(negedge clk); @(negedge clk);
        mem_ack = 1'b0; reset = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            set_inputs(32'h0);
            total++; if ({instr_valid, instr, mem_req, mem_addr} !== {exp_valid, exp_instr, m_req, m_addr}) begin bad++; $display("FAIL rst_restart c%0d: got v=%b i=%h r=%b a=%h want v=%b i=%h r=%b a=%h", i, instr_valid, instr, mem_req, mem_addr, exp_valid, exp_instr, m_req, m_addr); end
            if (i == 0) begin
                total++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL rst_ack_ignored: got r=%b v=%b want 0/0", mem_req, instr_valid); end
            end else if (i == 1) begin
                total++; if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin bad++; $display("FAIL rst_refetch: got r=%b a=%h want 1/%h", mem_req, mem_addr, RESET_PC); end
            end
            advance();
        end
    endtask

    task automatic test_misaligned();
        do_reset(); ws = 0;
        for (int i = 0; i < 4; i++) begin set_inputs(32'h0); advance(); end
        set_inputs(32'h2);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL misal_valid: got %b want 0", instr_valid); end
        advance();
        for (int i = 0; i < 5; i++) begin
            set_inputs(32'h0);
            total++; if ({instr_valid, instr, mem_req, mem_addr} !== {exp_valid, exp_instr, m_req, m_addr}) begin bad++; $display("FAIL misal_model c%0d: got v=%b i=%h r=%b a=%h want v=%b i=%h r=%b a=%h", i, instr_valid, instr, mem_req, mem_addr, exp_valid, exp_instr, m_req, m_addr); end
            if (i == 0) begin
                total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL misal_refetch: got r=%b a=%h want 1/00000000", mem_req, mem_addr); end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [31:0] p, np;
        int r;
        do_reset(); salt = 32'h5A5A_0000; rand_ws = 1'b1; ws = 1;
        p = 32'h0;
        for (int i = 0; i < 400; i++) begin
            set_inputs(p);
            total++; if ({instr_valid, instr, mem_req, mem_addr} !== {exp_valid, exp_instr, m_req, m_addr}) begin bad++; $display("FAIL rand_model c%0d pc=%h: got v=%b i=%h r=%b a=%h want v=%b i=%h r=%b a=%h", i, p, instr_valid, instr, mem_req, mem_addr, exp_valid, exp_instr, m_req, m_addr); end
            r = $urandom_range(0, 99);
            if (r < 4) np = 32'($urandom_range(0, 31)) << 2;
            else if (r < 6) np = p + 32'($urandom_range(1, 3));
            else if (r < 7) np = 32'hFFFF_FFF0;
            else if (r < 15) np = p + 32'd4;
            else np = exp_valid ? p + 32'd4 : {p[31:2], 2'b00};
            advance();
            p = np;
        end
        salt = 32'h0;
    endtask

    initial begin
        reset = 1'b0; pc = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        salt = 32'h0; ws = 0; wcnt = 0; rand_ws = 1'b0; cur_pc = 32'h0;
        model_reset();
        test_reset();
        test_first_fetch();
        test_stream(32'h0000_0000, 17);
        test_wait_states();
        test_flush_drop();
        test_reset_midop();
        test_stream(32'hFFFF_FFF8, 5);
        test_misaligned();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
